output_serializer: RTL

//  Serial transmitter on the read side of the SAP-1 output port: captures the word the bus

---
 rtl/output_serializer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/output_serializer.sv
// Serial transmitter for the SAP-1 output port: captures the bus word on a load and sends it
// as a start/data(LSB first)/stop frame. Define OUTPUT_SERIALIZER_PARITY_EN to add an even-parity bit.
module output_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             clk_en,
  input  logic             i_load_enable,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] shift_q;
  logic             tx_q;
  logic             busy_q;
  logic             overrun_q;
  logic             load_s;
  logic             bit_end_s;

`ifdef OUTPUT_SERIALIZER_PARITY_EN
  logic             parity_q;

  function automatic logic even_parity(input logic [WIDTH-1:0] data);
    return ^data;
  endfunction
`endif

  assign load_s    = clk_en & i_load_enable;
  assign bit_end_s = (cnt_q == CNT_LAST);

  assign o_tx      = tx_q;
  assign o_busy    = busy_q;
  assign o_overrun = overrun_q;

  // Frame sequencer: one bit timer shared by every state, outputs driven straight from registers
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      shift_q   <= {WIDTH{1'b0}};
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef OUTPUT_SERIALIZER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      // A load that finds the frame busy is dropped but remembered until reset
      if (load_s && busy_q) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          cnt_q <= {CNT_W{1'b0}};
          idx_q <= {IDX_W{1'b0}};
          if (load_s) begin
            shift_q  <= i_load_data;
`ifdef OUTPUT_SERIALIZER_PARITY_EN
            parity_q <= even_parity(i_load_data);
`endif
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_START;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end_s) begin
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end_s) begin
            cnt_q <= {CNT_W{1'b0}};
            if (idx_q == IDX_LAST) begin
`ifdef OUTPUT_SERIALIZER_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_end_s) begin
            cnt_q   <= {CNT_W{1'b0}};
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (bit_end_s) begin
            cnt_q   <= {CNT_W{1'b0}};
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= {CNT_W{1'b0}};
          idx_q   <= {IDX_W{1'b0}};
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
